// File: rtl/ls_ex_queue.sv
// Load/store execute queue: in-order FIFO of memory ops issued one at a
// time to the memory controller, load results returned with their ROB tag.
package ls_ex_queue_pkg;
    localparam int OPENUM_NOP = 0;
    localparam int OPENUM_LB  = 1;
    localparam int OPENUM_LH  = 2;
    localparam int OPENUM_LW  = 3;
    localparam int OPENUM_LBU = 4;
    localparam int OPENUM_LHU = 5;
    localparam int OPENUM_SB  = 6;
    localparam int OPENUM_SH  = 7;
    localparam int OPENUM_SW  = 8;
    localparam logic FLAG_READ  = 1'b0;
    localparam logic FLAG_WRITE = 1'b1;
endpackage

module ls_ex_queue
    import ls_ex_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int OPENUM_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [OPENUM_W-1:0] openum,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   store_value,
    input  logic [TAG_W-1:0]    rob_tag,
    output logic                full_to_lsb,
    output logic                ena_to_mc,
    output logic [ADDR_W-1:0]   addr_to_mc,
    output logic [DATA_W-1:0]   data_to_mc,
    output logic                wr_flag_to_mc,
    output logic [2:0]          size_to_mc,
    input  logic                ok_flag_from_mc,
    input  logic [DATA_W-1:0]   data_from_mc,
    output logic                valid,
    output logic [DATA_W-1:0]   result,
    output logic [TAG_W-1:0]    result_tag,
    input  logic                commit_jump_flag_from_rob
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, WAIT} state_t;
    typedef logic [OPENUM_W-1:0] op_t;

    function automatic logic is_op(input op_t op, input int code);
        return op == OPENUM_W'(code);
    endfunction

    function automatic logic is_load(input op_t op);
        return is_op(op, OPENUM_LB) || is_op(op, OPENUM_LH) ||
               is_op(op, OPENUM_LW) || is_op(op, OPENUM_LBU) ||
               is_op(op, OPENUM_LHU);
    endfunction

    function automatic logic is_store(input op_t op);
        return is_op(op, OPENUM_SB) || is_op(op, OPENUM_SH) ||
               is_op(op, OPENUM_SW);
    endfunction

    function automatic logic [2:0] size_of(input op_t op);
        logic [2:0] s;
        s = 3'd4;
        if (is_op(op, OPENUM_LB) || is_op(op, OPENUM_LBU) ||
            is_op(op, OPENUM_SB))
            s = 3'd1;
        else if (is_op(op, OPENUM_LH) || is_op(op, OPENUM_LHU) ||
                 is_op(op, OPENUM_SH))
            s = 3'd2;
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extend(input op_t op,
                                                 input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = DATA_W'($signed(d[31:0]));
        if (is_op(op, OPENUM_LB))  r = DATA_W'($signed(d[7:0]));
        if (is_op(op, OPENUM_LH))  r = DATA_W'($signed(d[15:0]));
        if (is_op(op, OPENUM_LBU)) r = DATA_W'(d[7:0]);
        if (is_op(op, OPENUM_LHU)) r = DATA_W'(d[15:0]);
        return r;
    endfunction

    op_t               op_q   [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] sval_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DEPTH-1:0]  killed_q;

    state_t           state_q;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flush, push, issue, drop, done, pop;
    logic             head_live;

    assign flush       = commit_jump_flag_from_rob;
    assign full_to_lsb = (count_q == CNT_W'(DEPTH));
    assign head_live   = is_load(op_q[head_q]) && !killed_q[head_q] && !flush;

    always_comb begin
        push = ena && !full_to_lsb &&
               (is_store(openum) || (is_load(openum) && !flush));
        issue   = (state_q == IDLE) && (count_q != '0) && !killed_q[head_q];
        drop    = (state_q == IDLE) && (count_q != '0) && killed_q[head_q];
        done    = (state_q == WAIT) && ok_flag_from_mc;
        pop     = drop || done;
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            killed_q      <= '0;
            ena_to_mc     <= 1'b0;
            addr_to_mc    <= '0;
            data_to_mc    <= '0;
            wr_flag_to_mc <= 1'b0;
            size_to_mc    <= '0;
            valid         <= 1'b0;
            result        <= '0;
            result_tag    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                addr_q[i] <= '0;
                sval_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid   <= 1'b0;
            // Kill loads first so a same-edge push can clear its own slot.
            if (flush) begin
                for (int i = 0; i < DEPTH; i++)
                    if (is_load(op_q[i])) killed_q[i] <= 1'b1;
            end
            if (push) begin
                op_q[tail_q]     <= openum;
                addr_q[tail_q]   <= mem_addr;
                sval_q[tail_q]   <= store_value;
                tag_q[tail_q]    <= rob_tag;
                killed_q[tail_q] <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q       <= WAIT;
                        ena_to_mc     <= 1'b1;
                        addr_to_mc    <= addr_q[head_q];
                        data_to_mc    <= sval_q[head_q];
                        size_to_mc    <= size_of(op_q[head_q]);
                        wr_flag_to_mc <= is_store(op_q[head_q]) ?
                                         FLAG_WRITE : FLAG_READ;
                    end
                end
                WAIT: begin
                    ena_to_mc <= 1'b0;
                    if (ok_flag_from_mc) begin
                        state_q <= IDLE;
                        if (head_live) begin
                            valid      <= 1'b1;
                            result     <= extend(op_q[head_q], data_from_mc);
                            result_tag <= tag_q[head_q];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
